// File: rtl/alu_mul_sched.sv
// alu_mul_sched: shares the single-cycle ALU between the datapath and an
// iterative shift-and-add multiplier (low word of the product).
// While idle or finishing, the ALU path is a transparent pass-through. While a
// multiply runs, the block issues one ADD per cycle and stalls the datapath.
//
// state | meaning
// IDLE  | pass-through, ready to accept mul_start
// RUN   | multiplier owns the ALU, one partial-product add per cycle
// DONE  | one-cycle completion pulse, pass-through restored

`ifndef WORDSIZE
`define WORDSIZE 64
`endif
`ifndef SHAMTSIZE
`define SHAMTSIZE 6
`endif
`ifndef ALUOPSIZE
`define ALUOPSIZE 4
`endif
`ifndef FLAGSIZE
`define FLAGSIZE 4
`endif
// aluop[3] = invert B, aluop[2] = shift enable, aluop[1:0] = function (00 = add)
`ifndef ALUOP_ADD
`define ALUOP_ADD 4'b0000
`endif

module alu_mul_sched #(
  parameter bit EARLY_EXIT = 1'b1,
  parameter int CNTW       = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [`WORDSIZE-1:0]  dp_a,
  input  logic [`WORDSIZE-1:0]  dp_b,
  input  logic [`SHAMTSIZE-1:0] dp_shamt,
  input  logic [`ALUOPSIZE-1:0] dp_aluop,
  output logic [`WORDSIZE-1:0]  dp_res,
  output logic [`FLAGSIZE-1:0]  dp_flags,
  output logic                  dp_flags_we,
  output logic                  stall,
  output logic [`WORDSIZE-1:0]  alu_a,
  output logic [`WORDSIZE-1:0]  alu_b,
  output logic [`SHAMTSIZE-1:0] alu_shamt,
  output logic [`ALUOPSIZE-1:0] alu_aluop,
  input  logic [`WORDSIZE-1:0]  alu_res,
  input  logic [`FLAGSIZE-1:0]  alu_flags,
  input  logic                  mul_start,
  input  logic [`WORDSIZE-1:0]  mul_a,
  input  logic [`WORDSIZE-1:0]  mul_b,
  input  logic                  mul_abort,
  output logic                  mul_ready,
  output logic                  mul_done,
  output logic [`WORDSIZE-1:0]  mul_res
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [`WORDSIZE-1:0] acc_q, acc_d;
  logic [`WORDSIZE-1:0] mcand_q, mcand_d;
  logic [`WORDSIZE-1:0] mplier_q, mplier_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [`WORDSIZE-1:0] mul_res_q;
  logic                 mul_done_q;
  logic                 mul_ready_q;
  logic                 run;
  logic                 last_iter;

  // ALU ownership mux and datapath return path, decoded from state
  always_comb begin
    run = (state_q == RUN);
    if (run) begin
      alu_a       = acc_q;
      alu_b       = mplier_q[0] ? mcand_q : '0;
      alu_shamt   = '0;
      alu_aluop   = `ALUOP_ADD;
      dp_res      = '0;
      dp_flags    = alu_flags;
      dp_flags_we = 1'b0;
      stall       = 1'b1;
    end else begin
      alu_a       = dp_a;
      alu_b       = dp_b;
      alu_shamt   = dp_shamt;
      alu_aluop   = dp_aluop;
      dp_res      = alu_res;
      dp_flags    = alu_flags;
      dp_flags_we = 1'b1;
      stall       = 1'b0;
    end
  end

  // Next values of the iteration registers; ALU carry-out is simply dropped
  always_comb begin
    acc_d     = alu_res;
    mcand_d   = mcand_q << 1;
    mplier_d  = mplier_q >> 1;
    cnt_d     = cnt_q + CNTW'(1);
    last_iter = (EARLY_EXIT && (mplier_d == '0)) ||
                (cnt_q == CNTW'(`WORDSIZE - 1));
  end

  // Scheduler FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      mul_res_q   <= '0;
      mul_done_q  <= 1'b0;
      mul_ready_q <= 1'b1;
    end else begin
      mul_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mul_start && !mul_abort) begin
            acc_q       <= '0;
            mcand_q     <= mul_a;
            mplier_q    <= mul_b;
            cnt_q       <= '0;
            mul_ready_q <= 1'b0;
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (mul_abort) begin
            mul_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            if (last_iter) begin
              mul_res_q  <= acc_d;
              mul_done_q <= 1'b1;
              state_q    <= DONE;
            end
          end
        end
        DONE: begin
          mul_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          mul_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign mul_ready = mul_ready_q;
  assign mul_done  = mul_done_q;
  assign mul_res   = mul_res_q;

endmodule

// File: doc/alu_mul_sched.md
Name: alu_mul_sched

Overview:
- Schedules the shared single-cycle ALU between the main datapath and an iterative shift-and-add multiplier (MUL, low word).
- When idle, the block is a transparent pass-through: datapath ALU requests go to the ALU and results come back unchanged.
- During a multiply, the block owns the ALU and drives one ADD per cycle. It raises `stall` so the datapath holds its instruction and suppresses flag writes.

Parameters:
- EARLY_EXIT, 1, 1 = stop iterating once the remaining multiplier bits are all zero; 0 = always run `WORDSIZE iterations.
- CNTW, 7, iteration counter width; must satisfy 2^CNTW > `WORDSIZE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dp_a  in  `WORDSIZE  datapath operand A.
- dp_b  in  `WORDSIZE  datapath operand B.
- dp_shamt  in  `SHAMTSIZE  datapath shift amount.
- dp_aluop  in  `ALUOPSIZE  datapath ALU operation.
- dp_res  out  `WORDSIZE  ALU result returned to datapath.
- dp_flags  out  `FLAGSIZE  ALU NZVC flags returned to datapath.
- dp_flags_we  out  1  qualifies dp_flags for the flags register.
- stall  out  1  ALU busy with multiply; datapath must hold.
- alu_a  out  `WORDSIZE  to ALU operand A.
- alu_b  out  `WORDSIZE  to ALU operand B.
- alu_shamt  out  `SHAMTSIZE  to ALU shift amount.
- alu_aluop  out  `ALUOPSIZE  to ALU operation.
- alu_res  in  `WORDSIZE  from ALU result.
- alu_flags  in  `FLAGSIZE  from ALU flags.
- mul_start  in  1  request multiply of mul_a by mul_b.
- mul_a  in  `WORDSIZE  multiplicand.
- mul_b  in  `WORDSIZE  multiplier.
- mul_abort  in  1  cancel an in-flight multiply.
- mul_ready  out  1  block can accept mul_start this cycle.
- mul_done  out  1  one-cycle pulse: mul_res is valid.
- mul_res  out  `WORDSIZE  product, low `WORDSIZE bits.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset state, asserted at any time including mid-multiply:
  - state = IDLE; acc, mcand, mplier, cnt and mul_res are all 0; mul_done = 0.
  - Outputs immediately become pass-through.
- States: IDLE, RUN, DONE.
- Pass-through (IDLE and DONE):
  - alu_* = dp_*.
  - dp_res = alu_res, dp_flags = alu_flags.
  - dp_flags_we = 1, stall = 0.
- IDLE:
  - mul_ready = 1.
  - On a clock edge with mul_start = 1 and mul_abort = 0, latch: acc = 0, mcand = mul_a, mplier = mul_b, cnt = 0. Go to RUN.
  - mul_start together with mul_abort: abort wins, stay in IDLE.
- RUN:
  - mul_ready = 0, stall = 1, dp_flags_we = 0, dp_res = 0.
  - ALU drives: alu_a = acc, alu_b = mplier[0] ? mcand : 0, alu_shamt = 0, alu_aluop = `ALUOP_ADD with no operand inversion and shift disabled.
  - Each edge updates: acc = alu_res; mcand = mcand << 1; mplier = mplier >> 1; cnt = cnt + 1.
  - Exit to DONE after the edge where (EARLY_EXIT and (mplier >> 1) == 0) or cnt == `WORDSIZE-1.
  - At least one RUN cycle always executes, including when mul_b = 0.
  - Carry out of bit `WORDSIZE-1 is discarded: the result is modulo 2^`WORDSIZE and is the same for signed and unsigned operands. alu_flags are ignored.
  - mul_abort = 1 at an edge in RUN: go to IDLE; no mul_done; mul_res keeps its previous value.
- DONE:
  - Lasts exactly one cycle: mul_done = 1, mul_res = acc (registered on entry to DONE).
  - mul_ready = 0; mul_start is ignored; next state is IDLE.
  - mul_abort in DONE has no effect.
- mul_res holds its value until the next completed multiply.
- Latency from the start edge to the mul_done cycle is N+1 cycles, where:
  - N = max(1, index of the highest set bit of mul_b + 1) when EARLY_EXIT = 1;
  - N = `WORDSIZE when EARLY_EXIT = 0.
- All alu_*, dp_res, dp_flags, dp_flags_we and stall are combinational from state and registers. mul_done, mul_ready and mul_res are registered or state-decoded.

Test Plan:
- Idle pass-through: dp_a = 5, dp_b = 3, dp_aluop = ADD -> alu_a = 5, dp_res = 8, dp_flags_we = 1, stall = 0 in the same cycle.
- Multiply 7 × 6 (EARLY_EXIT = 1):
  - stall is high for exactly 3 cycles;
  - alu_b sequence is 0, 14, 28;
  - mul_done pulses once with mul_res = 42; mul_ready returns 2 cycles after the last RUN edge.
- Wrap and full length (EARLY_EXIT = 0): 0xFFFFFFFFFFFFFFFF × 2 -> mul_res = 0xFFFFFFFFFFFFFFFE after 64 RUN cycles; a repeat with mul_b = 0 -> mul_res = 0.
- Abort: start 3 × 0x8000 and assert mul_abort on the 4th RUN cycle -> return to IDLE, no mul_done, mul_res unchanged, mul_ready = 1 next cycle.
- Reset mid-RUN: deassert rst_n asynchronously between edges -> stall = 0 and the pass-through path restored immediately, with mul_res = 0 and mul_done = 0.
- Start ignored: mul_start held high through RUN and DONE -> only one multiply executes; a new multiply is accepted only at the first IDLE edge.
